// File: rtl/d_trigger_line.sv
// ---------------------------------------------------------------------------
// d_trigger_line
//
// WIDTH-bit, DEPTH-stage registered delay line with a valid bit per stage,
// a global shift enable, a synchronous flush and a run-time selectable
// output tap. The latency is programmable from 1 to DEPTH cycles. A
// registered occupancy count reports how many stages hold valid data.
//
// Parameters
//   WIDTH       : data width in bits (>= 1)
//   DEPTH       : number of register stages (>= 2)
//   RESET_VALUE : value loaded into every data stage on reset and on clear
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-low reset
//   en        in   1      shift enable; 0 holds every stage
//   clr       in   1      synchronous flush; wins over en
//   in_valid  in   1      qualifies in
//   in        in   WIDTH  input data
//   delay     in   DW     tap select; latency = delay+1 (clamped to DEPTH)
//   out       out  WIDTH  data at the selected tap
//   out_valid out  1      valid bit at the selected tap
//   count     out  CW     number of stages currently holding valid data
// ---------------------------------------------------------------------------
module d_trigger_line #(
    parameter int                WIDTH       = 8,
    parameter int                DEPTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    localparam int               DW          = $clog2(DEPTH),
    localparam int               CW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [DW-1:0]    delay,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [CW-1:0]    count
);

    // Tap-select bounds, sized so the comparison below is width-exact.
    localparam logic [DW:0]   LP_DEPTH_W = (DW + 1)'(DEPTH);
    localparam logic [DW-1:0] LP_LAST    = DW'(DEPTH - 1);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [DEPTH-1:0] r_v;
    logic [CW-1:0]    r_count;

    logic [DW-1:0]    w_tap;
    logic [CW-1:0]    w_count_in;
    logic [CW-1:0]    w_count_out;

    // The occupancy count is maintained incrementally: on a shift one valid
    // bit may enter at stage 0 and one may leave from the last stage, so the
    // new count is the old count plus the entering bit minus the leaving bit.
    // This keeps count identical to popcount(v) without an adder tree.
    assign w_count_in  = CW'(in_valid);
    assign w_count_out = CW'(r_v[DEPTH-1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VALUE;
            end
            r_v     <= '0;
            r_count <= '0;
        end else if (clr) begin
            // Flush discards the sample presented on this edge as well.
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VALUE;
            end
            r_v     <= '0;
            r_count <= '0;
        end else if (en) begin
            // Bubbles shift like real samples; their valid bit travels along.
            r_stage[0] <= in;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_v     <= {r_v[DEPTH-2:0], in_valid};
            r_count <= r_count + w_count_in - w_count_out;
        end
    end

    // Out-of-range tap values (only possible when DEPTH is not a power of
    // two) are clamped to the last stage. A tap change is purely
    // combinational: in-flight data is simply viewed from the new position.
    assign w_tap = ({1'b0, delay} < LP_DEPTH_W) ? delay : LP_LAST;

    assign out       = r_stage[w_tap];
    assign out_valid = r_v[w_tap];
    assign count     = r_count;

endmodule

// File: tb/tb_d_trigger_line.sv
`timescale 1ns/1ps
module tb_d_trigger_line;

    localparam logic [7:0] RV8 = 8'h5A;
    localparam logic [7:0] RV6 = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       clr;
    logic       in_valid;
    logic [7:0] in_d;
    logic [2:0] delay8;
    logic [2:0] delay6;
    logic [7:0] out8, out6;
    logic       ov8, ov6;
    logic [3:0] cnt8;
    logic [2:0] cnt6;

    int n_chk  = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    d_trigger_line #(.WIDTH(8), .DEPTH(8), .RESET_VALUE(RV8)) u_dut8 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .in_valid(in_valid),
        .in(in_d), .delay(delay8), .out(out8), .out_valid(ov8), .count(cnt8)
    );

    d_trigger_line #(.WIDTH(8), .DEPTH(6), .RESET_VALUE(RV6)) u_dut6 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .in_valid(in_valid),
        .in(in_d), .delay(delay6), .out(out6), .out_valid(ov6), .count(cnt6)
    );

    // Reference model: the line is a history of the most recent DEPTH
    // shifted-in samples, newest first. The tap reads history entry d.
    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } ent_t;

    ent_t q8[$];
    ent_t q6[$];

    task automatic model_flush();
        q8.delete();
        q6.delete();
        for (int i = 0; i < 8; i++) q8.push_back('{d: RV8, v: 1'b0});
        for (int i = 0; i < 6; i++) q6.push_back('{d: RV6, v: 1'b0});
    endtask

    task automatic model_edge();
        ent_t e;
        if (clr) begin
            model_flush();
        end else if (en) begin
            e.d = in_d;
            e.v = in_valid;
            q8.push_front(e);
            void'(q8.pop_back());
            q6.push_front(e);
            void'(q6.pop_back());
        end
    endtask

    function automatic int tap_of(input int d, input int depth);
        return (d < depth) ? d : depth - 1;
    endfunction

    function automatic int occ8();
        int n = 0;
        foreach (q8[i]) if (q8[i].v) n++;
        return n;
    endfunction

    function automatic int occ6();
        int n = 0;
        foreach (q6[i]) if (q6[i].v) n++;
        return n;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int t8, t6;
        t8 = tap_of(int'(delay8), 8);
        t6 = tap_of(int'(delay6), 6);
        check_eq({tag, "/out8"}, 32'(out8), 32'(q8[t8].d));
        check_eq({tag, "/ov8"},  32'(ov8),  32'(q8[t8].v));
        check_eq({tag, "/cnt8"}, 32'(cnt8), 32'(occ8()));
        check_eq({tag, "/out6"}, 32'(out6), 32'(q6[t6].d));
        check_eq({tag, "/ov6"},  32'(ov6),  32'(q6[t6].v));
        check_eq({tag, "/cnt6"}, 32'(cnt6), 32'(occ6()));
    endtask

    // Sweeps every tap value (combinationally) and restores the previous taps.
    task automatic check_all_taps(input string tag);
        logic [2:0] s8, s6;
        s8 = delay8;
        s6 = delay6;
        for (int d = 0; d < 8; d++) begin
            delay8 = 3'(d);
            delay6 = 3'(d);
            #1;
            check_all(tag);
        end
        delay8 = s8;
        delay6 = s6;
        #0.5;
    endtask

    // One rising edge: the model consumes the same inputs as the DUTs, then
    // the outputs are compared 1ns after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        reset    = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_d     = 8'h00;
        delay8   = 3'd0;
        delay6   = 3'd0;
        model_flush();

        // Reset state, held across a few edges.
        repeat (3) @(posedge clk);
        #1;
        check_all_taps("reset");
        #2 reset = 1'b1;

        // Fixed latency with delay=3 on the 8-deep line.
        delay8 = 3'd3;
        en = 1'b1;
        in_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            in_d = 8'(8'h10 + k - 1);
            tick("latency");
            if (k >= 4) begin
                check_eq("latency_out", 32'(out8), 32'(8'h10 + k - 4));
                check_eq("latency_ov", 32'(ov8), 32'd1);
            end else begin
                check_eq("latency_ov_early", 32'(ov8), 32'd0);
            end
            check_eq("latency_cnt", 32'(cnt8), 32'((k < 8) ? k : 8));
        end

        // Reset asserted between edges takes effect immediately.
        for (int k = 1; k <= 8; k++) begin
            in_d = 8'(k);
            tick("fill");
        end
        reset = 1'b0;
        #1;
        check_eq("rst_mid_out", 32'(out8), 32'(RV8));
        check_eq("rst_mid_ov", 32'(ov8), 32'd0);
        check_eq("rst_mid_cnt", 32'(cnt8), 32'd0);
        model_flush();
        check_all("rst_mid");
        #2 reset = 1'b1;

        // Stall: the captured sample is held while en=0.
        delay8 = 3'd0;
        in_d = 8'hA5;
        in_valid = 1'b1;
        en = 1'b1;
        tick("stall_load");
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_d = 8'($urandom);
            in_valid = 1'($urandom);
            tick("stall");
            check_eq("stall_out", 32'(out8), 32'h0A5);
            check_eq("stall_ov", 32'(ov8), 32'd1);
            check_eq("stall_cnt", 32'(cnt8), 32'd1);
        end

        // Clear wins over en and discards the input on that edge.
        en = 1'b1;
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_d = 8'(k);
            tick("clr_load");
        end
        clr = 1'b1;
        in_d = 8'hFF;
        tick("clr_edge");
        clr = 1'b0;
        check_eq("clr_cnt", 32'(cnt8), 32'd0);
        check_all_taps("clr_taps");
        in_valid = 1'b0;
        in_d = 8'h00;
        for (int k = 0; k < 9; k++) begin
            tick("clr_drain");
            check_eq("clr_no_ff", 32'(out8 == 8'hFF), 32'd0);
        end

        // Bubbles, then a tap change without clocking.
        clr = 1'b1;
        tick("bub_clr");
        clr = 1'b0;
        delay8 = 3'd3;
        for (int k = 0; k < 4; k++) begin
            in_d = 8'(k + 1);
            in_valid = (k != 1);
            tick("bubble");
        end
        check_eq("bub_ov4", 32'(ov8), 32'd1);
        check_eq("bub_cnt", 32'(cnt8), 32'd3);
        delay8 = 3'd0;
        #1;
        check_eq("tap_out", 32'(out8), 32'h04);
        check_eq("tap_ov", 32'(ov8), 32'd1);
        check_all("tap_chg");
        delay8 = 3'd3;
        in_valid = 1'b0;
        in_d = 8'h00;
        for (int k = 5; k <= 7; k++) begin
            tick("bubble_tail");
            check_eq("bub_ov_seq", 32'(ov8), 32'((k == 5) ? 0 : 1));
        end

        // Clamp on the 6-deep line: delay=7 acts as delay=5 (6 edges).
        clr = 1'b1;
        tick("clamp_clr");
        clr = 1'b0;
        delay6 = 3'd7;
        in_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            in_d = 8'(8'h30 + k - 1);
            tick("clamp");
            if (k >= 6) begin
                check_eq("clamp_out", 32'(out6), 32'(8'h30 + k - 6));
                check_eq("clamp_ov", 32'(ov6), 32'd1);
            end else begin
                check_eq("clamp_ov_early", 32'(ov6), 32'd0);
            end
        end

        // Randomised traffic with occasional resets and mid-cycle tap changes.
        for (int n = 0; n < 600; n++) begin
            en       = ($urandom_range(3) != 0);
            clr      = ($urandom_range(19) == 0);
            in_valid = 1'($urandom);
            in_d     = 8'($urandom);
            delay8   = 3'($urandom);
            delay6   = 3'($urandom);
            tick("rand");
            if ($urandom_range(49) == 0) begin
                reset = 1'b0;
                #1;
                model_flush();
                check_all("rand_rst");
                #1 reset = 1'b1;
            end else if ($urandom_range(3) == 0) begin
                delay8 = 3'($urandom);
                delay6 = 3'($urandom);
                #1;
                check_all("rand_tap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/d_trigger_line.md
# d_trigger_line

Parametrised successor to the 8-bit `d_trigger` register. `d_trigger_line` is a WIDTH-bit, DEPTH-stage registered delay line. It has:
- a per-stage valid bit,
- a global clock enable (stall),
- a synchronous flush,
- a run-time selectable output tap, so the latency is programmable from 1 to DEPTH cycles.

It sits between producers and consumers that need a retimed or delay-matched copy of a data stream. An occupancy count is provided for monitoring.

## Interface
Parameters:
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 8, number of register stages (≥2)
- RESET_VALUE, 0, value loaded into every data stage on reset and on clear

Ports (DW = $clog2(DEPTH), CW = $clog2(DEPTH+1)):
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  shift enable; 0 = hold all stages
- clr  in  1  synchronous flush
- in_valid  in  1  qualifies `in`
- in  in  WIDTH  input data
- delay  in  DW  output tap select; latency = delay+1 cycles
- out  out  WIDTH  data at the selected tap
- out_valid  out  1  valid bit at the selected tap
- count  out  CW  number of stages currently holding valid data

## Operation
- Storage: DEPTH data registers `stage[0..DEPTH-1]` and DEPTH valid bits `v[0..DEPTH-1]`.
- Reset (reset=0, asynchronous, no clock needed):
  - all `stage` = RESET_VALUE;
  - all `v` = 0;
  - therefore out = RESET_VALUE, out_valid = 0, count = 0.
  - The reset holds for as long as reset=0 and overrides clr and en.
- Per rising edge when reset=1, priority order:
  1. clr=1: all `stage` = RESET_VALUE and all `v` = 0. This applies regardless of en, and the input on that edge is discarded.
  2. else en=1 (shift):
     - stage[0] ← in, v[0] ← in_valid;
     - stage[i] ← stage[i-1], v[i] ← v[i-1] for 1 ≤ i < DEPTH;
     - contents of stage[DEPTH-1] are dropped.
  3. else (en=0): hold all stages and valid bits.
- Data is shifted even when in_valid=0; the valid bit travels with it. Invalid slots are bubbles, not skipped.
- Tap select (combinational from registers):
  - out = stage[d], out_valid = v[d];
  - d = delay if delay < DEPTH, else DEPTH-1 (clamp when DEPTH is not a power of two).
- delay change mid-stream: takes effect immediately, with no flush and no re-timing. Data already in flight is presented from the new tap, so samples may be repeated or skipped; that is the caller's responsibility.
- count = popcount(v). It is registered state derived from v, so it updates on the same edge as v.
- No arithmetic on data; data is passed bit-exact.

## Timing
- Latency: a sample presented with en=1 at edge N appears on out after edge N+d, i.e. d+1 edges including capture, provided en stays 1.
- Each en=0 cycle adds one cycle of latency to every sample in flight.
- out/out_valid change only on clk edges, on a reset assertion, or combinationally on a delay change.
- Reset deassertion must be synchronous to clk externally. The first capture is on the first rising edge with reset=1.
- clr and en are sampled on the rising edge. clr with en=1 on the same edge: clear wins.
- The line is full when count = DEPTH. There is no backpressure: the oldest entry is silently dropped on the next shift.

## Test plan
- Reset mid-stream:
  - stimulus: fill with in = 1..8, in_valid=1, then pull reset low between edges;
  - required: out = RESET_VALUE, out_valid = 0 and count = 0 immediately, before the next edge.
- Fixed latency, WIDTH=8, DEPTH=8, delay=3:
  - stimulus: stream in = 0x10, 0x11, … with in_valid=1, en=1;
  - required: 0x10 appears on out with out_valid=1 after the 4th edge, followed by one increment per edge;
  - required: count saturates at 8 after 8 edges.
- Stall:
  - stimulus: delay=0, drive in = 0xA5 at an edge, then en=0 for 3 edges while `in` changes;
  - required: out holds 0xA5, out_valid stays 1, and count is unchanged for all 3 edges.
- Clear priority:
  - stimulus: 5 valid samples loaded; on one edge drive clr=1, en=1, in = 0xFF, in_valid=1;
  - required after that edge: count = 0, out_valid = 0, out = RESET_VALUE for every delay value;
  - required: the 0xFF sample never appears.
- Bubbles and tap change:
  - stimulus: in_valid pattern 1,0,1,1 with data 0x01..0x04, delay=3;
  - required: out_valid = 1,0,1,1 on successive edges starting at the 4th, and count = 3;
  - stimulus: then switch delay to 0 without clocking;
  - required: out = 0x04, out_valid = 1 on the same cycle.
- Clamp, DEPTH=6 (DW=3):
  - stimulus: delay=7;
  - required: behaves identically to delay=5, with a latency of 6 edges.
